// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/redirect controller:
// stall vector layout, FSM state encodings and the default exception vector.
package pipeline_ctrl_pkg;

  localparam int STALL_W   = 6;
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  // PEND holds every live register without inserting a bubble anywhere
  localparam logic [STALL_W-1:0] STALL_FREEZE = 6'b011111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_stall_priority_enc.sv
// Combinational stall-request encoder: the highest requesting stage stalls itself
// and everything upstream; priority MEM > EX > ID > IF. The WB bit is never set.
module stall_priority_enc
  import pipeline_ctrl_pkg::*;
(
  input  logic               req_if,
  input  logic               req_id,
  input  logic               req_ex,
  input  logic               req_mem,
  output logic [STALL_W-1:0] stall
);

  always_comb begin
    stall = '0;
    if (req_mem)     stall = 6'b011111;
    else if (req_ex) stall = 6'b001111;
    else if (req_id) stall = 6'b000111;
    else if (req_if) stall = 6'b000011;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage core, with deferred redirect
// while a fetch is in flight. Optional counters: define PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = ADDR_WIDTH'(EXC_VECTOR_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_req_if,
  input  logic                  stall_req_id,
  input  logic                  stall_req_ex,
  input  logic                  stall_req_mem,
  input  logic                  exc_valid,
  input  logic                  exc_eret,
  input  logic [ADDR_WIDTH-1:0] cp0_epc,
  output logic [STALL_W-1:0]    stall,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] flush_pc,
  output logic                  busy
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
`endif
);

  state_t                  state, state_nxt;
  logic [STALL_W-1:0]      enc_stall;
  logic [STALL_W-1:0]      stall_cmb;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   accept_target;
  logic [ADDR_WIDTH-1:0]   target_p0;
  logic [ADDR_WIDTH-1:0]   flush_pc_p0;

  stall_priority_enc u_enc (
    .req_if  (stall_req_if),
    .req_id  (stall_req_id),
    .req_ex  (stall_req_ex),
    .req_mem (stall_req_mem),
    .stall   (enc_stall)
  );

  // A MEM-stage exception is only taken once its own memory access has drained
  assign accept        = (state == ST_IDLE) && exc_valid && !stall_req_mem;
  assign accept_target = exc_eret ? cp0_epc : EXC_VECTOR;

  always_comb begin
    state_nxt = state;
    stall_cmb = '0;
    case (state)
      ST_IDLE: begin
        stall_cmb = enc_stall;
        if (accept) state_nxt = stall_req_if ? ST_PEND : ST_FLUSH;
      end
      ST_PEND: begin
        stall_cmb = STALL_FREEZE;
        if (!stall_req_if) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign stall = rst ? stall_cmb : '0;
  assign flush = (state == ST_FLUSH);
  assign busy  = (state == ST_PEND);
  assign flush_pc = flush_pc_p0;

  // -- state / target register stage --
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      target_p0   <= '0;
      flush_pc_p0 <= '0;
    end else begin
      state <= state_nxt;
      if (accept) target_p0 <= accept_target;
      if (state_nxt == ST_FLUSH)
        flush_pc_p0 <= (state == ST_IDLE) ? accept_target : target_p0;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall[STALL_PC]) stall_cycles <= stall_cycles + 32'd1;
      if (flush)           flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver queues hand-computed expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_req_if = 1'b0, stall_req_id = 1'b0;
  logic        stall_req_ex = 1'b0, stall_req_mem = 1'b0;
  logic        exc_valid = 1'b0, exc_eret = 1'b0;
  logic [31:0] cp0_epc = '0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        busy;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  pipeline_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall_req_if  (stall_req_if),
    .stall_req_id  (stall_req_id),
    .stall_req_ex  (stall_req_ex),
    .stall_req_mem (stall_req_mem),
    .exc_valid     (exc_valid),
    .exc_eret      (exc_eret),
    .cp0_epc       (cp0_epc),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .busy          (busy)
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          step;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          step_no = 0;
  logic [31:0] run_sc = '0;
  logic [31:0] run_fc = '0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (stall !== e.stall) begin
        errors++;
        $display("FAIL stall step %0d: got %b expected %b", e.step, stall, e.stall);
      end
      checks++;
      if (flush !== e.flush) begin
        errors++;
        $display("FAIL flush step %0d: got %b expected %b", e.step, flush, e.flush);
      end
      checks++;
      if (flush_pc !== e.pc) begin
        errors++;
        $display("FAIL flush_pc step %0d: got %h expected %h", e.step, flush_pc, e.pc);
      end
      checks++;
      if (busy !== e.busy) begin
        errors++;
        $display("FAIL busy step %0d: got %b expected %b", e.step, busy, e.busy);
      end
`ifdef PIPELINE_CTRL_PERF_EN
      checks++;
      if (stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL stall_cycles step %0d: got %0d expected %0d", e.step, stall_cycles, e.sc);
      end
      checks++;
      if (flush_count !== e.fc) begin
        errors++;
        $display("FAIL flush_count step %0d: got %0d expected %0d", e.step, flush_count, e.fc);
      end
`endif
    end
  end

  // One cycle: drive inputs just after the edge, queue the outputs expected at the following negedge
  task automatic cyc(input logic r, input logic rif, input logic rid, input logic rex,
                     input logic rmem, input logic ev, input logic er, input logic [31:0] epc,
                     input logic [5:0] es, input logic ef, input logic [31:0] ep, input logic eb);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall_req_if = rif; stall_req_id = rid; stall_req_ex = rex;
    stall_req_mem = rmem; exc_valid = ev; exc_eret = er; cp0_epc = epc;
    step_no++;
    if (!r) begin
      run_sc = '0;
      run_fc = '0;
    end
    e.step = step_no; e.stall = es; e.flush = ef; e.pc = ep; e.busy = eb;
    e.sc = run_sc; e.fc = run_fc;
    q.push_back(e);
    if (r) begin
      run_sc = run_sc + 32'(es[0]);
      run_fc = run_fc + 32'(ef);
    end
  endtask

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam logic [31:0] EPC = 32'h8000_1234;

  initial begin
    // reset: requests present but stall forced low
    cyc(0, 0,0,1,0, 0,0,32'h0,        6'b000000, 0, 32'h0, 0);
    cyc(0, 0,0,0,0, 0,0,32'h0,        6'b000000, 0, 32'h0, 0);
    cyc(1, 0,0,0,0, 0,0,32'h0,        6'b000000, 0, 32'h0, 0);
    // EX stall for exactly three cycles
    repeat (3) cyc(1, 0,0,1,0, 0,0,32'h0, 6'b001111, 0, 32'h0, 0);
    cyc(1, 0,0,0,0, 0,0,32'h0,        6'b000000, 0, 32'h0, 0);
    cyc(1, 0,1,0,0, 0,0,32'h0,        6'b000111, 0, 32'h0, 0);
    // IF+MEM: MEM wins, then IF alone
    cyc(1, 1,0,0,1, 0,0,32'h0,        6'b011111, 0, 32'h0, 0);
    cyc(1, 1,0,0,0, 0,0,32'h0,        6'b000011, 0, 32'h0, 0);
    cyc(1, 0,0,0,0, 0,0,32'h0,        6'b000000, 0, 32'h0, 0);
    // plain exception: flush to the vector one cycle later
    cyc(1, 0,0,0,0, 1,0,32'h0,        6'b000000, 0, 32'h0, 0);
    cyc(1, 0,0,0,0, 0,0,32'h0,        6'b000000, 1, VEC,   0);
    cyc(1, 0,0,0,0, 0,0,32'h0,        6'b000000, 0, VEC,   0);
    // ERET with fetch in flight: four PEND cycles, an ignored exception inside
    cyc(1, 1,0,0,0, 1,1,EPC,          6'b000011, 0, VEC,   0);
    cyc(1, 1,0,0,0, 0,0,32'h0,        6'b011111, 0, VEC,   1);
    cyc(1, 1,0,0,1, 1,0,32'h0,        6'b011111, 0, VEC,   1);
    cyc(1, 1,0,0,0, 0,0,32'h0,        6'b011111, 0, VEC,   1);
    cyc(1, 0,0,0,0, 0,0,32'h0,        6'b011111, 0, VEC,   1);
    cyc(1, 0,0,0,0, 0,0,32'h0,        6'b000000, 1, EPC,   0);
    cyc(1, 0,0,0,0, 0,0,32'h0,        6'b000000, 0, EPC,   0);
    // eret without valid has no effect
    cyc(1, 0,0,0,0, 0,1,32'hDEADBEEF, 6'b000000, 0, EPC,   0);
    cyc(1, 0,0,0,0, 0,0,32'h0,        6'b000000, 0, EPC,   0);
    // exception held off by MEM stall, second pulse during FLUSH ignored
    cyc(1, 0,0,0,1, 1,0,32'h0,        6'b011111, 0, EPC,   0);
    cyc(1, 0,0,0,1, 1,0,32'h0,        6'b011111, 0, EPC,   0);
    cyc(1, 0,0,0,0, 1,0,32'h0,        6'b000000, 0, EPC,   0);
    cyc(1, 0,0,0,0, 1,1,32'hCAFE0000, 6'b000000, 1, VEC,   0);
    cyc(1, 0,0,0,0, 0,0,32'h0,        6'b000000, 0, VEC,   0);
    cyc(1, 0,0,0,0, 0,0,32'h0,        6'b000000, 0, VEC,   0);
    // reset in PEND aborts the redirect
    cyc(1, 1,0,0,0, 1,1,32'h12345678, 6'b000011, 0, VEC,   0);
    cyc(1, 1,0,0,0, 0,0,32'h0,        6'b011111, 0, VEC,   1);
    cyc(0, 1,0,0,0, 0,0,32'h0,        6'b000000, 0, 32'h0, 0);
    cyc(1, 0,0,0,0, 0,0,32'h0,        6'b000000, 0, 32'h0, 0);
    cyc(1, 0,0,0,0, 0,0,32'h0,        6'b000000, 0, 32'h0, 0);
    cyc(1, 0,0,0,0, 0,0,32'h0,        6'b000000, 0, 32'h0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected records left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard/redirect controller for the 5-stage core.
- Collects per-stage stall requests and the committed-exception/ERET request from MEM.
- Drives the stall and flush inputs of every pipeline register: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- Supplies the redirect PC to the fetch unit.
- Owns the sequencing of deferred flushes that arrive while an instruction fetch is still in flight.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception handler address used for non-ERET redirects.
- ADDR_WIDTH, 32, width of PC/EPC buses.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset: asynchronous, active-low.
- stall_req_if  in  1  fetch busy (I-cache/bus miss in flight).
- stall_req_id  in  1  load-use or branch operand hazard.
- stall_req_ex  in  1  multi-cycle mul/div busy.
- stall_req_mem  in  1  D-cache/bus access pending.
- exc_valid  in  1  MEM-stage instruction raises an exception or is ERET.
- exc_eret  in  1  qualifies exc_valid as ERET.
- cp0_epc  in  ADDR_WIDTH  current EPC from CP0.
- stall  out  6  stall vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB (reserved).
- flush  out  1  clear all pipeline registers this cycle.
- flush_pc  out  ADDR_WIDTH  redirect target, valid while flush=1.
- busy  out  1  high in PEND state.

Behaviour:
- Reset (rst=0, async): state=IDLE; stall=0; flush=0; flush_pc=0; busy=0; target register=0.

Stall encoding (combinational, IDLE only):
- Find the highest requesting stage, priority MEM > EX > ID > IF.
- MEM: stall[4:0]=5'b11111.
- EX: stall=6'b001111.
- ID: stall=6'b000111.
- IF: stall=6'b000011.
- None: stall=0.
- stall[5] is always 0.
- The register just downstream of the highest stalled register receives stall_current=1, stall_next=0, and therefore inserts a bubble.

Exception acceptance:
- Accepted only when exc_valid=1 and stall_req_mem=0 in IDLE.
- Target = cp0_epc if exc_eret, else EXC_VECTOR.
- The target is latched at the clock edge.

State machine:
- IDLE, acceptance with stall_req_if=0: go to FLUSH.
- IDLE, acceptance with stall_req_if=1: go to PEND. The in-flight fetch must complete before the redirect.
- PEND: stall=6'b011111 (freeze, no bubbles); busy=1; flush=0.
  - Stays in PEND while stall_req_if=1.
  - Goes to FLUSH on the first cycle stall_req_if=0.
- FLUSH: exactly one cycle.
  - flush=1, flush_pc=latched target, stall=0.
  - Always returns to IDLE.
- Flush latency: FLUSH is entered 1 cycle after an accepted request with no pending fetch.

Outputs and boundary cases:
- flush and flush_pc are registered outputs. flush_pc holds its last value when flush=0.
- Any exc_valid in PEND or FLUSH is ignored. The flushed MEM instruction cannot re-raise.
- exc_valid together with stall_req_mem=1: not accepted; the stall vector applies. Acceptance happens on the later cycle when stall_req_mem=0.
- exc_eret=1 with exc_valid=0 has no effect.
- Reset asserted in PEND or FLUSH aborts immediately to IDLE with outputs cleared. No redirect is issued.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_EN.
- When defined, two 32-bit outputs are added:
  - stall_cycles: increments on every cycle with stall[0]=1, including PEND.
  - flush_count: increments on every FLUSH cycle.
- Both counters are cleared by reset and wrap modulo 2^32.
- When undefined, the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package/define header holds:
  - stage bit indices (STALL_PC..STALL_WB);
  - stall vector width 6;
  - state encodings IDLE/PEND/FLUSH (2 bits);
  - EXC_VECTOR default constant.
- One natural sub-module, stall_priority_enc: purely combinational request-to-stall-vector encoder, instantiated once.
- The FSM and target register stay in pipeline_ctrl.

Test Plan:
- stall_req_ex=1 only, for 3 cycles -> stall=6'b001111 for exactly those 3 cycles; flush=0 throughout.
- stall_req_if=1 and stall_req_mem=1 together -> stall=6'b011111 (MEM wins); release MEM only -> stall=6'b000011 next cycle.
- exc_valid=1, exc_eret=0, no stalls -> next cycle flush=1, flush_pc=32'hBFC00380, stall=0; following cycle flush=0.
- exc_valid=1, exc_eret=1, cp0_epc=32'h8000_1234, stall_req_if=1 held 4 cycles -> busy=1 and stall=6'b011111 for 4 cycles; then a single flush with flush_pc=32'h8000_1234.
- exc_valid=1 with stall_req_mem=1 for 2 cycles, then stall_req_mem=0 -> no flush during the 2 cycles; flush one cycle after release. A second exc_valid pulse during FLUSH -> no second flush.
- rst driven low in PEND -> outputs immediately 0 and no flush after release. With PIPELINE_CTRL_PERF_EN: stall_cycles and flush_count read 0 after reset, then count correctly over scenarios 1–4.
